// File: rtl/ariane_pkg.sv
// Shared core types: AMO opcodes and the AMO/store responder FSM states.
package ariane_pkg;

  typedef enum logic [3:0] {
    AMO_NONE = 4'b0000,
    AMO_LR   = 4'b0001,
    AMO_SC   = 4'b0010,
    AMO_SWAP = 4'b0011,
    AMO_ADD  = 4'b0100,
    AMO_AND  = 4'b0101,
    AMO_OR   = 4'b0110,
    AMO_XOR  = 4'b0111,
    AMO_MAX  = 4'b1000,
    AMO_MAXU = 4'b1001,
    AMO_MIN  = 4'b1010,
    AMO_MINU = 4'b1011,
    AMO_CAS1 = 4'b1100,
    AMO_CAS2 = 4'b1101
  } amo_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    AMO_READ  = 2'd1,
    AMO_WRITE = 2'd2,
    AMO_ACK   = 2'd3
  } amo_resp_state_t;

  function automatic logic amo_writes(amo_t op);
    return op inside {AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR,
                      AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU};
  endfunction

endpackage

// File: rtl/amo_resp_alu.sv
// Combinational AMO arithmetic; for word ops only new_o[31:0] is meaningful.
module amo_resp_alu
  import ariane_pkg::*;
(
  input  amo_t        op_i,
  input  logic [1:0]  size_i,
  input  logic [63:0] old_i,
  input  logic [63:0] operand_i,
  output logic [63:0] new_o
);

  logic        is_word;
  logic        lt_s;
  logic        lt_u;
  logic [63:0] sum;

  always_comb begin
    is_word = (size_i == 2'b10);
    lt_s    = is_word ? ($signed(old_i[31:0]) < $signed(operand_i[31:0]))
                      : ($signed(old_i) < $signed(operand_i));
    lt_u    = is_word ? (old_i[31:0] < operand_i[31:0]) : (old_i < operand_i);
    sum     = old_i + operand_i;
    new_o   = old_i;
    case (op_i)
      AMO_SWAP, AMO_SC: new_o = operand_i;
      AMO_ADD:          new_o = sum;
      AMO_AND:          new_o = old_i & operand_i;
      AMO_OR:           new_o = old_i | operand_i;
      AMO_XOR:          new_o = old_i ^ operand_i;
      AMO_MAX:          new_o = lt_s ? operand_i : old_i;
      AMO_MAXU:         new_o = lt_u ? operand_i : old_i;
      AMO_MIN:          new_o = lt_s ? old_i : operand_i;
      AMO_MINU:         new_o = lt_u ? old_i : operand_i;
      default:          new_o = old_i;
    endcase
  end

endmodule

// File: rtl/amo_store_responder.sv
// Store/AMO responder over a DEPTH x 64-bit memory; stores win over AMOs in IDLE.
// Define AMO_RESPONDER_LRSC_EN to enable the LR/SC reservation; otherwise SC always fails.
module amo_store_responder
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        st_req_i,
  output logic        st_gnt_o,
  input  logic [63:0] st_addr_i,
  input  logic [63:0] st_wdata_i,
  input  logic [7:0]  st_be_i,
  input  logic        amo_req_i,
  input  amo_t        amo_op_i,
  input  logic [63:0] amo_addr_i,
  input  logic [63:0] amo_operand_i,
  input  logic [1:0]  amo_size_i,
  output logic        amo_ack_o,
  output logic [63:0] amo_result_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [63:0]     mem_q [DEPTH];
  amo_resp_state_t state_q;
  amo_t            op_q;
  logic [1:0]      size_q;
  logic [IDX_W-1:0] idx_q;
  logic            half_q;
  logic [63:0]     operand_q;
  logic [63:0]     old_q;
  logic [63:0]     result_q;
  logic            ack_q;

  logic [IDX_W-1:0] st_idx;
  logic             is_word;
  logic [31:0]      old_half;
  logic [63:0]      alu_old;
  logic [63:0]      alu_new;
  logic [63:0]      merged;
  logic [63:0]      old_ext;
  logic [63:0]      result_d;
  logic             sc_ok;
  logic             amo_we;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{st_addr_i[63:IDX_W+3], st_addr_i[2:0],
                              amo_addr_i[63:IDX_W+3], amo_addr_i[1:0]};

  assign st_idx   = st_addr_i[3 +: IDX_W];
  assign st_gnt_o = st_req_i && (state_q == IDLE) && rst_ni;

  amo_resp_alu u_alu (
    .op_i      (op_q),
    .size_i    (size_q),
    .old_i     (alu_old),
    .operand_i (operand_q),
    .new_o     (alu_new)
  );

  // Word ops run on the selected half; the untouched half is merged back in.
  always_comb begin
    is_word  = (size_q == 2'b10);
    old_half = half_q ? old_q[63:32] : old_q[31:0];
    alu_old  = is_word ? {32'd0, old_half} : old_q;
    old_ext  = is_word ? {{32{old_half[31]}}, old_half} : old_q;
    if (!is_word)    merged = alu_new;
    else if (half_q) merged = {alu_new[31:0], old_q[31:0]};
    else             merged = {old_q[63:32], alu_new[31:0]};
    amo_we   = (state_q == AMO_WRITE) && (amo_writes(op_q) || ((op_q == AMO_SC) && sc_ok));
    result_d = old_ext;
    case (op_q)
      AMO_NONE, AMO_CAS1, AMO_CAS2: result_d = '0;
      AMO_SC:                       result_d = {63'd0, ~sc_ok};
      default:                      ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (st_gnt_o) begin
      for (int b = 0; b < 8; b++) begin
        if (st_be_i[b]) mem_q[st_idx][8*b +: 8] <= st_wdata_i[8*b +: 8];
      end
    end else if (amo_we) begin
      mem_q[idx_q] <= merged;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      op_q      <= AMO_NONE;
      size_q    <= 2'b11;
      idx_q     <= '0;
      half_q    <= 1'b0;
      operand_q <= '0;
      old_q     <= '0;
      result_q  <= '0;
      ack_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (amo_req_i && !st_req_i) begin
            op_q      <= amo_op_i;
            size_q    <= amo_size_i;
            idx_q     <= amo_addr_i[3 +: IDX_W];
            half_q    <= amo_addr_i[2];
            operand_q <= amo_operand_i;
            state_q   <= AMO_READ;
          end
        end
        AMO_READ: begin
          old_q   <= mem_q[idx_q];
          state_q <= AMO_WRITE;
        end
        AMO_WRITE: begin
          result_q <= result_d;
          ack_q    <= 1'b1;
          state_q  <= AMO_ACK;
        end
        AMO_ACK: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AMO_RESPONDER_LRSC_EN
  logic             resv_valid_q;
  logic [IDX_W-1:0] resv_idx_q;

  assign sc_ok = resv_valid_q && (resv_idx_q == idx_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resv_valid_q <= 1'b0;
      resv_idx_q   <= '0;
    end else if (st_gnt_o && (st_idx == resv_idx_q)) begin
      resv_valid_q <= 1'b0;
    end else if (state_q == AMO_WRITE) begin
      if (op_q == AMO_LR) begin
        resv_valid_q <= 1'b1;
        resv_idx_q   <= idx_q;
      end else if (op_q == AMO_SC) begin
        resv_valid_q <= 1'b0;
      end else if (amo_we && (idx_q == resv_idx_q)) begin
        resv_valid_q <= 1'b0;
      end
    end
  end
`else
  assign sc_ok = 1'b0;
`endif

  assign amo_ack_o    = ack_q;
  assign amo_result_o = result_q;

endmodule

// File: doc/amo_store_responder.md
AMO_STORE_RESPONDER -- requirements
Module: amo_store_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 64-bit memory words (power of two, 2..4096).
REQ-002 SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port st_req_i, input, 1 bit: store request valid.
REQ-005 SHALL have port st_gnt_o, output, 1 bit: store accepted this cycle.
REQ-006 SHALL have port st_addr_i, input, 64 bits: store byte address.
REQ-007 SHALL have port st_wdata_i, input, 64 bits: store data, already lane-aligned.
REQ-008 SHALL have port st_be_i, input, 8 bits: store byte enables.
REQ-009 SHALL have port amo_req_i, input, 1 bit: AMO request, held high until ack.
REQ-010 SHALL have port amo_op_i, input, amo_t: AMO operation.
REQ-011 SHALL have port amo_addr_i, input, 64 bits: AMO byte address.
REQ-012 SHALL have port amo_operand_i, input, 64 bits: AMO operand, unshifted.
REQ-013 SHALL have port amo_size_i, input, 2 bits: 2'b10 is word, 2'b11 is doubleword.
REQ-014 SHALL have port amo_ack_o, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port amo_result_o, output, 64 bits: AMO old value or SC status.

Function
REQ-016 SHALL form the word index as addr[3 +: log2(DEPTH)]; higher address bits are ignored (wrap-around).
REQ-017 SHALL implement FSM IDLE -> AMO_READ -> AMO_WRITE -> AMO_ACK -> IDLE.
REQ-018 SHALL assert st_gnt_o combinationally when st_req_i is high and state is IDLE; stores stall in every other state.
REQ-019 SHALL write st_wdata_i bytes selected by st_be_i at the clock edge of the grant; st_be_i = 0 writes nothing but is still granted.
REQ-020 SHALL give a store priority over an AMO in IDLE; the AMO starts in the first IDLE cycle with st_req_i low.
REQ-021 SHALL in AMO_READ register the addressed memory word.
REQ-022 SHALL in AMO_WRITE compute the new value per amo_op_i (SWAP, ADD, AND, OR, XOR, MAX, MAXU, MIN, MINU) and write it back.
REQ-023 SHALL in AMO_ACK assert amo_ack_o for exactly one cycle, so ack comes 3 cycles after acceptance.
REQ-024 SHALL for word AMOs operate on the 32-bit half selected by amo_addr_i[2], using signed/unsigned 32-bit compare and wrapping 32-bit add, and leave the other half unchanged.
REQ-025 SHALL return the old value as amo_result_o, sign-extended to 64 bits for word ops.
REQ-026 SHALL treat AMO_LR as a read only, with no write in AMO_WRITE.
REQ-027 SHALL treat AMO_SC as a write of the operand only if it succeeds; result is 0 on success, 1 on failure.
REQ-028 SHALL treat AMO_NONE as a no-op, acknowledged with result 0.
REQ-029 SHALL hold amo_result_o stable from AMO_ACK until the next AMO acknowledgment.
REQ-030 SHALL complete an AMO even if amo_req_i drops mid-operation.

Reset
REQ-031 SHALL on rst_ni low force state IDLE, amo_ack_o 0, amo_result_o 0, and the reservation invalid.
REQ-032 SHALL leave memory contents unreset.
REQ-033 SHALL produce no write when reset asserts mid-AMO.

Configuration
REQ-034 SHALL, with AMO_RESPONDER_LRSC_EN defined, make LR set a reservation (valid bit plus dword index).
REQ-035 SHALL clear the reservation on any granted store or AMO write to the reserved dword, and on every SC.
REQ-036 SHALL succeed an SC only when the reservation is valid and the index matches.
REQ-037 SHALL, without AMO_RESPONDER_LRSC_EN, have no reservation logic; LR is a plain read and SC always fails (result 1, no write).

Structure
REQ-038 SHALL reuse amo_t from ariane_pkg.
REQ-039 SHALL add amo_resp_state_t (the four FSM states) to ariane_pkg.
REQ-040 SHALL put the ALU in one combinational sub-module amo_resp_alu (op, size, old value, operand -> new value); memory and FSM stay in the top.

Verification
REQ-041 SHALL cover: store addr 0x08, data 0x1122334455667788, be 0xFF, then AMO_ADD dword 0x08 operand 1 -> result 0x1122334455667788, memory 0x1122334455667789, ack 3 cycles after accept.
REQ-042 SHALL cover: word AMO_MIN addr 0x04, memory upper half 0x00000005, operand 0xFFFFFFFF -> result 0x5, upper half 0xFFFFFFFF, lower half unchanged.
REQ-043 SHALL cover: LR 0x40, then SC 0x40 -> result 0; LR 0x40, store 0x40, SC 0x40 -> result 1, memory keeps the store data; run without the macro -> SC always 1.
REQ-044 SHALL cover: st_req_i and amo_req_i rising in the same cycle -> store granted first, AMO accepted the next cycle; a store arriving during AMO_READ -> st_gnt_o low until IDLE.
REQ-045 SHALL cover: DEPTH=256, store to 0x808 -> overwrites index 1 (wrap).
REQ-046 SHALL cover: reset asserted in AMO_WRITE -> memory unchanged, ack never seen, FSM in IDLE.
